// File: rtl/boot_loader_pkg.sv
// Shared types and helpers for the boot ROM copy engine.
// One 64-bit word moves through READ then WRITE for each index.
package boot_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } loader_state_e;

   localparam int WORD_BYTES = 8;

   function automatic logic [63:0] bswap64(input logic [63:0] d);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < WORD_BYTES; i++) begin
         r[8*i +: 8] = d[8*(WORD_BYTES-1-i) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/boot_rom_loader.sv
// Boot-time copy engine: streams NUM_WORDS words from the boot ROM into system
// memory over a req/gnt write port, then holds a sticky done flag.
module boot_rom_loader
   import boot_loader_pkg::*;
#(
   parameter logic [63:0] SRC_BASE   = 64'h1000,
   parameter logic [63:0] DST_BASE   = 64'h8000_0000,
   parameter int          NUM_WORDS  = 261,
   parameter bit          SWAP_BYTES = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic [63:0] rom_addr_o,
   input  logic [63:0] rom_data_i,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic        mem_we_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   output logic [7:0]  mem_be_o,
   output logic        busy_o,
   output logic        done_o
);

   // A zero-word build still needs a legal (1-bit) index register.
   localparam int IDX_W = (NUM_WORDS > 0) ? $clog2(NUM_WORDS + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = (NUM_WORDS > 0) ? IDX_W'(NUM_WORDS - 1) : '0;

   loader_state_e    r_state;
   loader_state_e    w_state_next;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_next;
   logic [63:0]      r_data;
   logic [63:0]      w_src_addr;
   logic [63:0]      w_dst_addr;
   logic             w_req;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         if (r_state == READ) begin
            r_data <= SWAP_BYTES ? bswap64(rom_data_i) : rom_data_i;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      case (r_state)
         IDLE, DONE: begin
            if (start_i) begin
               if (NUM_WORDS == 0) begin
                  w_state_next = DONE;
               end else begin
                  w_state_next = READ;
                  w_idx_next   = '0;
               end
            end
         end
         READ: begin
            w_state_next = WRITE;
         end
         WRITE: begin
            // Request fields derive from r_idx/r_data, so they hold until grant.
            if (mem_gnt_i) begin
               if (r_idx == LAST_IDX) begin
                  w_state_next = DONE;
               end else begin
                  w_state_next = READ;
                  w_idx_next   = r_idx + IDX_W'(1);
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign w_src_addr = SRC_BASE + (64'(r_idx) * 64'(WORD_BYTES));
   assign w_dst_addr = DST_BASE + (64'(r_idx) * 64'(WORD_BYTES));
   assign w_req      = (r_state == WRITE);

   assign rom_addr_o  = (r_state == READ) ? w_src_addr : SRC_BASE;
   assign mem_req_o   = w_req;
   assign mem_we_o    = w_req;
   assign mem_be_o    = {8{w_req}};
   assign mem_addr_o  = w_req ? w_dst_addr : 64'd0;
   assign mem_wdata_o = w_req ? r_data : 64'd0;
   assign busy_o      = (r_state == READ) || (r_state == WRITE);
   assign done_o      = (r_state == DONE);

endmodule

// File: doc/boot_rom_loader.md
# boot_rom_loader

Boot-time copy engine on the initiator side of the boot ROM's address/data read port. On `start_i` it reads `NUM_WORDS` consecutive 64-bit words from the ROM and writes each one to system memory over a req/gnt write port. Typical use is staging the boot header and device tree from ROM into DRAM before the core is released. It then reports completion to the platform control logic.

## Interface
- `SRC_BASE`, default 64'h1000: byte address of the first ROM word; must be 8-byte aligned.
- `DST_BASE`, default 64'h8000_0000: byte address of the first destination word; must be 8-byte aligned.
- `NUM_WORDS`, default 261: number of 64-bit words copied; 0 is legal.
- `SWAP_BYTES`, default 1'b0: when 1, the byte order of each 64-bit word is reversed before it is written.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  single-cycle start pulse
- `rom_addr_o`  out  64  ROM read address
- `rom_data_i`  in  64  ROM read data, combinational from `rom_addr_o` in the same cycle
- `mem_req_o`  out  1  write request
- `mem_gnt_i`  in  1  write grant
- `mem_we_o`  out  1  write enable, always 1 while `mem_req_o` is high
- `mem_addr_o`  out  64  write address
- `mem_wdata_o`  out  64  write data
- `mem_be_o`  out  8  byte enables, always 8'hFF while `mem_req_o` is high
- `busy_o`  out  1  high while a copy is in progress
- `done_o`  out  1  sticky completion flag

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - `start_i` with `NUM_WORDS`>0: go to READ; the index is cleared to 0.
  - `start_i` with `NUM_WORDS`==0: go directly to DONE.
- READ, one cycle:
  - `rom_addr_o` = `SRC_BASE` + 8·idx.
  - `rom_data_i` is captured into the data register at the cycle's end, byte-swapped if `SWAP_BYTES`.
  - Next state is WRITE.
- WRITE:
  - `mem_req_o`=1, `mem_addr_o` = `DST_BASE` + 8·idx, `mem_wdata_o` = the data register.
  - All request fields are held stable until `mem_gnt_i`=1.
  - On grant with idx == `NUM_WORDS`-1: go to DONE. On grant otherwise: idx+1 and go to READ.
- DONE:
  - `done_o`=1 and stays high.
  - `start_i` clears `done_o` and restarts the copy exactly as from IDLE.
- `start_i` in READ or WRITE is ignored.
- Index counter width is $clog2(`NUM_WORDS`+1). Address arithmetic is 64-bit modulo 2^64; no overflow detection.
- `rom_addr_o` = `SRC_BASE` outside READ. `mem_addr_o` and `mem_wdata_o` are 0 when `mem_req_o`=0.
- `busy_o` = (state is READ or WRITE).

## Timing
- Reset values: state IDLE, idx 0, `mem_req_o`/`mem_we_o`/`busy_o`/`done_o` = 0, `mem_be_o` = 0, `mem_addr_o`/`mem_wdata_o` = 0, `rom_addr_o` = `SRC_BASE`.
- `start_i` sampled at edge n: READ in cycle n+1, first `mem_req_o` in cycle n+2.
- A grant in the same cycle the request is raised completes that word. Best case is 2 cycles per word and 2·`NUM_WORDS` cycles total.
- `done_o` rises in the cycle after the last grant.
- `start_i` coincident with the last grant (in WRITE) is ignored; the engine still ends in DONE.
- Once raised, `mem_req_o` never drops without a grant. The only exception is `rst_i`.
- Reset mid-operation: at the next edge the block returns to IDLE and `mem_req_o` drops. No partial-word state survives.
- No combinational path from any input to any output except `rom_data_i`, which feeds the capture register only.

## Structure
- `boot_loader_pkg` holds:
  - `loader_state_e` enum (IDLE, READ, WRITE, DONE);
  - `WORD_BYTES` = 8;
  - a `bswap64` function used when `SWAP_BYTES`=1.
- Single flat module; no sub-module is warranted. The ROM is an external instance, not embedded.

## Test plan
- Basic copy, `NUM_WORDS`=4, gnt tied to 1:
  - writes to 8000_0000, 8000_0008, 8000_0010 and 8000_0018 carry ROM words 1000 through 1018 in order (1018 holds 64'h0000_0000_8000_0000);
  - `done_o` is high 8 cycles after `start_i`.
- Backpressure, gnt low for 3 cycles on word 1: req, addr and data stay stable for the whole stall; the total copy is 11 cycles.
- Byte swap, `SWAP_BYTES`=1, ROM word 64'h0011223344556677: written data is 64'h7766554433221100.
- `NUM_WORDS`=0: `start_i` leads to `done_o`=1 the next cycle, with no `mem_req_o` ever asserted.
- Restart and ignore:
  - `start_i` pulses during WRITE have no effect;
  - `start_i` in DONE clears `done_o` and repeats an identical write sequence.
- Reset on word 2 while `mem_req_o`=1 and gnt=0: the next cycle has `mem_req_o`=0, `busy_o`=0, `done_o`=0; a following `start_i` restarts at `SRC_BASE`.
